crc_check_scheduler: RTL and testbench

Shares one serial CRC-4 engine among the 16 channel inputs (64-bit word plus 4-bit CRC each) of the top-level FPGA datapath. A round-robin arbiter grants one requesting channel, captures its word, computes CRC-4 at 8 bits per cycle, then returns either a check verdict or the generated CRC with the channel index. A saturating mismatch counter is maintained.

---
 rtl/crc_sched_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/crc_check_scheduler.sv | 149 ++++++++++++++
 tb/tb_crc_check_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_sched_pkg.sv
// Shared definitions for the CRC check scheduler.
//   NCH/DW/CW/BPC : channel count, word width, CRC width, bits per engine cycle
//   CRC_POLY      : x^4 + x + 1 with the x^4 term implied
//   state_t       : scheduler FSM encoding (IDLE, RUN, DONE)
package crc_sched_pkg;

  localparam int NCH    = 16;
  localparam int DW     = 64;
  localparam int CW     = 4;
  localparam int BPC    = 8;
  localparam int IDX_W  = $clog2(NCH);
  localparam int BEATS  = DW / BPC;
  localparam int BEAT_W = $clog2(BEATS);

  localparam logic [CW-1:0] CRC_POLY = 4'h3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among NCH requests.
//   clock, reset_n : clock and synchronous active-low reset
//   req            : request vector
//   update         : load last_grant with the current winner (handshake)
//   grant          : one-hot grant (combinational, zero when no request)
//   grant_idx      : binary index of the granted request
// The search starts one past the previous winner, so a channel that just
// won drops to lowest priority. The pointer resets to NCH-1 so channel 0
// wins the first tie.
module rr_arbiter
  import crc_sched_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic [NCH-1:0]   req,
  input  logic             update,
  output logic [NCH-1:0]   grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = IDX_W'((int'(last_q) + 1 + i) % NCH);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_q <= IDX_W'(NCH - 1);
    end else if (update) begin
      last_q <= grant_idx;
    end
  end

endmodule

// File: rtl/crc_check_scheduler.sv
// Shares one CRC-4 engine (x^4+x+1, MSB first, init 0) among NCH channels.
//   clock, reset_n : clock and synchronous active-low reset
//   req_valid/req_ready : per-channel request, one-hot grant (IDLE only)
//   data_in, crc_in     : channel words and received CRCs, channel i at slice i
//   mod1                : 1 = check received CRC, 0 = generate CRC
//   res_valid/res_ready : result handshake; res_chan/res_crc/res_ok held in DONE
//   busy                : FSM not in IDLE
//   err_count           : saturating count of check-mode mismatches
//   fsm_state           : current FSM state for observation
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid never depends on ready, and res_* stay frozen while
// res_valid is high and res_ready is low.
module crc_check_scheduler
  import crc_sched_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NCH-1:0]    req_valid,
  output logic [NCH-1:0]    req_ready,
  input  logic [NCH*DW-1:0] data_in,
  input  logic [NCH*CW-1:0] crc_in,
  input  logic              mod1,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDX_W-1:0]  res_chan,
  output logic [CW-1:0]     res_crc,
  output logic              res_ok,
  output logic              busy,
  output logic [15:0]       err_count,
  output state_t            fsm_state
);

  // BPC message bits folded into the CRC, MSB first.
  function automatic logic [CW-1:0] crc_step(input logic [CW-1:0] crc,
                                             input logic [BPC-1:0] bits);
    logic [CW-1:0] c;
    logic          fb;
    c = crc;
    for (int i = BPC - 1; i >= 0; i--) begin
      fb = c[CW-1] ^ bits[i];
      c  = {c[CW-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [NCH-1:0]   grant;
  logic [IDX_W-1:0] grant_idx;
  logic             handshake;

  logic [DW-1:0]     data_q;
  logic [CW-1:0]     crc_q;
  logic [CW-1:0]     crc_rx_q;
  logic              mode_q;
  logic [IDX_W-1:0]  chan_q;
  logic [BEAT_W-1:0] beat_q;
  logic              ok_q;
  logic [15:0]       err_q;

  logic [CW-1:0]     crc_next;
  logic              last_beat;

  rr_arbiter u_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req_valid),
    .update    (handshake),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grants are masked while reset is asserted so no handshake can slip
  // through in the same cycle the FSM is being cleared.
  assign req_ready = (state_q == IDLE && reset_n) ? grant : '0;
  assign handshake = |(req_valid & req_ready);

  // The word is shifted left each beat, so the next BPC bits are always on top.
  assign crc_next  = crc_step(crc_q, data_q[DW-1 -: BPC]);
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = RUN;
      RUN:     if (last_beat) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_q   <= '0;
      crc_q    <= '0;
      crc_rx_q <= '0;
      mode_q   <= 1'b0;
      chan_q   <= '0;
      beat_q   <= '0;
      ok_q     <= 1'b0;
      err_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (handshake) begin
            data_q   <= data_in[int'(grant_idx)*DW +: DW];
            crc_rx_q <= crc_in[int'(grant_idx)*CW +: CW];
            mode_q   <= mod1;
            chan_q   <= grant_idx;
            crc_q    <= '0;
            beat_q   <= '0;
            ok_q     <= 1'b0;
          end
        end
        RUN: begin
          data_q <= data_q << BPC;
          crc_q  <= crc_next;
          beat_q <= beat_q + BEAT_W'(1);
          if (last_beat) begin
            ok_q <= mode_q ? (crc_next == crc_rx_q) : 1'b1;
          end
        end
        DONE: begin
          // Count once, at the result handshake, and stick at all-ones.
          if (res_ready && mode_q && !ok_q && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_chan  = chan_q;
  assign res_crc   = crc_q;
  assign res_ok    = ok_q;
  assign err_count = err_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_crc_check_scheduler.sv
// Testbench for crc_check_scheduler: directed table, round-robin sweep,
// result back-pressure, mid-run reset, randomized traffic and counter
// saturation, all against a long-division CRC model and a round-robin model.
module tb_crc_check_scheduler;
  import crc_sched_pkg::*;

  // ---------------- clock / reset ----------------
  logic              clock = 1'b0;
  logic              reset_n;
  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_ready;
  logic [NCH*DW-1:0] data_in;
  logic [NCH*CW-1:0] crc_in;
  logic              mod1;
  logic              res_valid;
  logic              res_ready;
  logic [IDX_W-1:0]  res_chan;
  logic [CW-1:0]     res_crc;
  logic              res_ok;
  logic              busy;
  logic [15:0]       err_count;
  state_t            fsm_state;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  crc_check_scheduler dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .data_in   (data_in),
    .crc_in    (crc_in),
    .mod1      (mod1),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_chan  (res_chan),
    .res_crc   (res_crc),
    .res_ok    (res_ok),
    .busy      (busy),
    .err_count (err_count),
    .fsm_state (fsm_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [8:0] exp_q[$];   // {chan, crc, ok}
  int m_last = NCH - 1;
  int m_err  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic die(input string name);
    n_err++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $fatal(1, "timeout");
  endtask

  // CRC as the remainder of Data(x)*x^4 divided by x^4+x+1 (long division).
  function automatic logic [3:0] ref_crc(input logic [63:0] d);
    logic [67:0] r;
    r = {d, 4'b0000};
    for (int i = 67; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  function automatic int rr_pick(input logic [15:0] mask);
    for (int i = 1; i <= NCH; i++) begin
      if (mask[(m_last + i) % NCH]) return (m_last + i) % NCH;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge after inputs were driven; returns the grant cycle.
  task automatic wait_grant(input int exp_ch, output int t, output int waits);
    int idx;
    waits = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (|req_ready) begin
        idx = -1;
        for (int c = 0; c < NCH; c++) if (req_ready[c]) idx = c;
        check("grant_onehot", $countones(req_ready), 1);
        check("grant_chan", idx, exp_ch);
        t = cyc;
        return;
      end
      waits++;
      @(negedge clock);
    end
    die("wait_grant");
  endtask

  // Waits for the result of a handshake at cycle t_hs, stalls res_ready,
  // then accepts it. Returns at the negedge of the first IDLE cycle.
  task automatic collect(input int t_hs, input int stall);
    logic [8:0] e;
    logic [8:0] snap;
    int bad;
    for (int k = 0; k < 20 && !res_valid; k++) @(negedge clock);
    if (!res_valid) die("collect");
    check("latency", cyc - t_hs, 9);
    e = exp_q.pop_front();
    check("res_chan", res_chan, e[8:5]);
    check("res_crc", res_crc, e[4:1]);
    check("res_ok", res_ok, e[0]);
    snap = {res_chan, res_crc, res_ok};
    bad = 0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clock);
      if (!res_valid || {res_chan, res_crc, res_ok} !== snap || req_ready !== '0) bad++;
    end
    if (stall > 0) check("hold_stable", bad, 0);
    res_ready = 1'b1;
    @(negedge clock);
    res_ready = 1'b0;
    if (!e[0]) m_err = (m_err == 65535) ? 65535 : m_err + 1;
    check("idle_res_valid", res_valid, 0);
    check("idle_busy", busy, 0);
    check("err_count", err_count, m_err);
  endtask

  // One transaction; channel data must already be on data_in/crc_in.
  task automatic do_txn(input logic [15:0] mask, input logic m, input int stall,
                        input logic use_tab, input logic [3:0] tab_crc,
                        input logic tab_ok, output int waits);
    int ch, t;
    logic [63:0] d;
    logic [3:0] c, ec;
    logic eo;
    req_valid = req_valid | mask;
    mod1 = m;
    ch = rr_pick(req_valid);
    wait_grant(ch, t, waits);
    d  = data_in[ch*DW +: DW];
    c  = crc_in[ch*CW +: CW];
    ec = use_tab ? tab_crc : ref_crc(d);
    eo = use_tab ? tab_ok : (m ? (ec == c) : 1'b1);
    exp_q.push_back({4'(ch), ec, eo});
    m_last = ch;
    @(negedge clock);
    check("run_busy", busy, 1);
    check("run_req_ready", req_ready, 0);
    // Inputs change after capture; the in-flight word must not notice.
    req_valid[ch] = 1'b0;
    data_in[ch*DW +: DW] = ~d;
    crc_in[ch*CW +: CW] = ~c;
    mod1 = ~m;
    collect(t, stall);
  endtask

  // ---------------- test ----------------
  typedef struct {
    int          ch;
    logic [63:0] d;
    logic [3:0]  c;
    logic        m;
    logic [3:0]  exp_crc;
    logic        exp_ok;
    int          exp_err;
  } vec_t;

  vec_t tab[7];

  initial begin
    int w, t;
    logic [15:0] mask;
    logic m;
    int grants, results, prev, idx, exp_ch;
    logic [8:0] e;

    tab[0] = '{0,  64'h1,                  4'h1, 1'b1, 4'h3, 1'b0, 1};
    tab[1] = '{5,  64'h2,                  4'h0, 1'b0, 4'h6, 1'b1, 1};
    tab[2] = '{5,  64'h10,                 4'h0, 1'b0, 4'h5, 1'b1, 1};
    tab[3] = '{5,  64'h0,                  4'h7, 1'b0, 4'h0, 1'b1, 1};
    tab[4] = '{7,  64'h10,                 4'h5, 1'b1, 4'h5, 1'b1, 1};
    tab[5] = '{9,  64'h8000_0000_0000_0000, 4'hB, 1'b1, 4'hB, 1'b1, 1};
    tab[6] = '{12, 64'h4,                  4'h0, 1'b1, 4'hC, 1'b0, 2};

    reset_n = 1'b0; req_valid = '0; data_in = '0; crc_in = '0;
    mod1 = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_req_ready", req_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_chan", res_chan, 0);
    check("rst_res_crc", res_crc, 0);
    check("rst_res_ok", res_ok, 0);
    check("rst_busy", busy, 0);
    check("rst_err_count", err_count, 0);
    check("rst_state", fsm_state, IDLE);
    reset_n = 1'b1;

    // Directed table: single requester, back-to-back, grant expected at once.
    for (int i = 0; i < 7; i++) begin
      data_in[tab[i].ch*DW +: DW] = tab[i].d;
      crc_in[tab[i].ch*CW +: CW] = tab[i].c;
      do_txn(16'(1 << tab[i].ch), tab[i].m, 0, 1'b1, tab[i].exp_crc, tab[i].exp_ok, w);
      check("tab_grant_wait", w, 0);
      check("tab_err_count", err_count, tab[i].exp_err);
    end

    // All channels requesting, res_ready tied high: 17 grants, 10 cycles apart.
    for (int c = 0; c < NCH; c++) begin
      data_in[c*DW +: DW] = {$urandom, $urandom};
      crc_in[c*CW +: CW] = 4'($urandom_range(0, 15));
    end
    mod1 = 1'b1; res_ready = 1'b1; req_valid = '1;
    grants = 0; results = 0; prev = -1;
    for (int k = 0; k < 250 && results < 17; k++) begin
      #1;
      if (|req_ready && grants < 17) begin
        exp_ch = rr_pick(req_valid);
        idx = -1;
        for (int c = 0; c < NCH; c++) if (req_ready[c]) idx = c;
        check("rr_chan", idx, exp_ch);
        if (prev >= 0) check("rr_period", cyc - prev, 10);
        prev = cyc;
        exp_q.push_back({4'(exp_ch), ref_crc(data_in[exp_ch*DW +: DW]),
                         ref_crc(data_in[exp_ch*DW +: DW]) == crc_in[exp_ch*CW +: CW]});
        m_last = exp_ch;
        grants++;
      end
      if (res_valid) begin
        e = exp_q.pop_front();
        check("rr_res", {res_chan, res_crc, res_ok}, e);
        if (!e[0]) m_err = (m_err == 65535) ? 65535 : m_err + 1;
        results++;
        if (results == 17) req_valid = '0;
      end
      @(negedge clock);
    end
    check("rr_results", results, 17);
    res_ready = 1'b0;
    @(negedge clock);
    check("rr_err_count", err_count, m_err);

    // Back-pressure: 20 stalled cycles with another channel waiting.
    data_in[11*DW +: DW] = {$urandom, $urandom};
    req_valid[11] = 1'b1;
    data_in[10*DW +: DW] = {$urandom, $urandom};
    do_txn(16'h0400, 1'b0, 20, 1'b0, 4'h0, 1'b0, w);
    do_txn(16'h0000, 1'b0, 0, 1'b0, 4'h0, 1'b0, w);
    check("after_stall_grant_wait", w, 0);

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      mask = 16'($urandom_range(1, 65535));
      for (int c = 0; c < NCH; c++) begin
        data_in[c*DW +: DW] = {$urandom, $urandom};
        crc_in[c*CW +: CW] = 4'($urandom_range(0, 15));
      end
      exp_ch = rr_pick(mask);
      if ($urandom_range(0, 1) == 1)
        crc_in[exp_ch*CW +: CW] = ref_crc(data_in[exp_ch*DW +: DW]);
      m = 1'($urandom_range(0, 1));
      do_txn(mask, m, $urandom_range(0, 3), 1'b0, 4'h0, 1'b0, w);
      check("rand_grant_wait", w, 0);
      req_valid = '0;
    end

    // Reset at RUN beat 4 of a ch3 word.
    data_in[3*DW +: DW] = 64'hDEAD_BEEF_0123_4567;
    crc_in[3*CW +: CW] = 4'h0;
    mod1 = 1'b0;
    req_valid[3] = 1'b1;
    wait_grant(rr_pick(req_valid), t, w);
    m_last = 3;
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_res_chan", res_chan, 0);
    check("mid_rst_res_crc", res_crc, 0);
    check("mid_rst_res_ok", res_ok, 0);
    check("mid_rst_err_count", err_count, 0);
    @(negedge clock);
    check("mid_rst_no_pulse", res_valid, 0);
    m_last = NCH - 1;
    m_err = 0;
    reset_n = 1'b1;
    data_in[5*DW +: DW] = {$urandom, $urandom};
    req_valid[5] = 1'b1;
    // Priority restarts at ch0, so ch3 wins over ch5.
    do_txn(16'h0000, 1'b0, 0, 1'b0, 4'h0, 1'b0, w);
    do_txn(16'h0000, 1'b0, 0, 1'b0, 4'h0, 1'b0, w);

    // Saturation: preload near the top, then force three mismatches.
    force dut.err_q = 16'hFFFD;
    @(negedge clock);
    release dut.err_q;
    m_err = 65533;
    @(negedge clock);
    check("sat_preload", err_count, 16'hFFFD);
    for (int i = 0; i < 3; i++) begin
      data_in[6*DW +: DW] = {$urandom, $urandom};
      crc_in[6*CW +: CW] = ref_crc(data_in[6*DW +: DW]) ^ 4'hF;
      do_txn(16'h0040, 1'b1, 0, 1'b0, 4'h0, 1'b0, w);
    end
    check("sat_final", err_count, 16'hFFFF);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    die("global_watchdog");
  end

endmodule
